// File: rtl/spart_pkg.sv
// Shared types for the SPART receive path.
package spart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/spart_fifo.sv
// Generic synchronous show-ahead FIFO; head entry is visible on rdata while not empty.
module spart_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count   = wptr_q - rptr_q;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receive path: oversampling deframer with parity/framing checks feeding a show-ahead FIFO.
module spart_rx_fifo
   import spart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned OVS        = 16,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rxd,
   input  logic [DIV_W-1:0]                divisor,
   input  logic                            parity_en,
   input  logic                            parity_odd,
   input  logic                            rd_en,
   output logic [DATA_BITS-1:0]            rd_data,
   output logic                            rd_perr,
   output logic                            rd_ferr,
   output logic                            empty,
   output logic                            full,
   output logic [$clog2(FIFO_DEPTH):0]     count,
   output logic                            overrun,
   input  logic                            clr_err
);

   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      logic                 perr;
      logic                 ferr;
   } rx_entry_t;

   localparam int unsigned    TCW        = $clog2(OVS);
   localparam int unsigned    BCW        = $clog2(DATA_BITS);
   localparam logic [TCW-1:0] START_LAST = TCW'(OVS / 2 - 2);
   localparam logic [TCW-1:0] BIT_LAST   = TCW'(OVS - 1);
   localparam logic [BCW-1:0] DATA_LAST  = BCW'(DATA_BITS - 1);

   logic                 sync1_q, rxs_q;
   logic [DIV_W-1:0]     div_cnt_q, div_lim_q, div_eff;
   logic                 tick;
   rx_state_t            state_q, state_d;
   logic                 smp;
   logic [TCW-1:0]       tc_q, tc_d;
   logic [BCW-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 par_en_q, par_en_d;
   logic                 par_odd_q, par_odd_d;
   logic                 push_q, push_d;
   rx_entry_t            entry_q, entry_d, head;
   logic                 drop, overrun_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxs_q   <= sync1_q;
      end
   end

   // The limit is reloaded only on wrap so a divisor change never truncates a tick period.
   assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
   assign tick    = (div_cnt_q == div_lim_q - DIV_W'(1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt_q <= '0;
         div_lim_q <= div_eff;
      end else if (tick) begin
         div_cnt_q <= '0;
         div_lim_q <= div_eff;
      end else begin
         div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         tc_q      <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         push_q    <= 1'b0;
         entry_q   <= '0;
      end else begin
         state_q   <= state_d;
         tc_q      <= tc_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         perr_q    <= perr_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         push_q    <= push_d;
         entry_q   <= entry_d;
      end
   end

   always_comb begin
      smp     = 1'b0;
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (tick && !rxs_q) state_d = START;
         START: begin
            smp = tick && (tc_q == START_LAST);
            if (smp) state_d = rxs_q ? IDLE : DATA;
         end
         DATA: begin
            smp = tick && (tc_q == BIT_LAST);
            if (smp && bit_q == DATA_LAST) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            smp = tick && (tc_q == BIT_LAST);
            if (smp) state_d = STOP;
         end
         STOP: begin
            smp = tick && (tc_q == BIT_LAST);
            if (smp) state_d = rxs_q ? IDLE : BREAK;
         end
         BREAK:  if (tick && rxs_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tc_d      = tc_q;
      bit_d     = bit_q;
      data_d    = data_q;
      perr_d    = perr_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      push_d    = 1'b0;
      entry_d   = entry_q;
      if (state_d != state_q || smp) begin
         tc_d = '0;
      end else if (tick) begin
         tc_d = tc_q + TCW'(1);
      end
      unique case (state_q)
         START: begin
            if (smp && !rxs_q) begin
               bit_d     = '0;
               perr_d    = 1'b0;
               par_en_d  = parity_en;
               par_odd_d = parity_odd;
            end
         end
         DATA: begin
            if (smp) begin
               data_d = {rxs_q, data_q[DATA_BITS-1:1]};
               bit_d  = bit_q + BCW'(1);
            end
         end
         PARITY: if (smp) perr_d = (((^data_q) ^ rxs_q) != par_odd_q);
         STOP: begin
            if (smp) begin
               push_d  = 1'b1;
               entry_d = {data_q, perr_q, ~rxs_q};
            end
         end
         default: ;
      endcase
   end

   spart_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .wdata (entry_q),
      .pop   (rd_en),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without one.
   assign drop = push_q && full && !(rd_en && !empty);

   always_ff @(posedge clk) begin
      if (!rst) begin
         overrun_q <= 1'b0;
      end else if (drop) begin
         overrun_q <= 1'b1;
      end else if (clr_err) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun = overrun_q;
   assign rd_data = head.data;
   assign rd_perr = head.perr;
   assign rd_ferr = head.ferr;

endmodule
